lane_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one downstream channel between SIZE lanes.
//  The lanes are the per-lane signals of an SVI array, one lane per element.

---
 rtl/lane_arb_pkg.sv | 15 +
 rtl/lane_rr_arbiter_rr_pick.sv | 35 +++
 rtl/lane_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_lane_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_arb_pkg.sv
// Shared types and default sizing for the lane round-robin arbiter.
package lane_arb_pkg;

  localparam int unsigned LANE_SIZE = 8;
  localparam int unsigned LANE_W    = 8;

  typedef logic [$clog2(LANE_SIZE)-1:0] lane_idx_t;
  typedef logic [LANE_W-1:0]            lane_data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/lane_rr_arbiter_rr_pick.sv
// Round-robin pick: first requester strictly after i_ptr, wrapping modulo SIZE.
module rr_pick
  import lane_arb_pkg::*;
#(
  parameter int unsigned SIZE = LANE_SIZE
) (
  input  logic [SIZE-1:0]         i_req,
  input  logic [$clog2(SIZE)-1:0] i_ptr,
  output logic                    o_any,
  output logic [$clog2(SIZE)-1:0] o_idx
);

  localparam int unsigned IW = $clog2(SIZE);

  int unsigned w_pos;
  logic        w_found;

  // Walking positions ptr+1 .. ptr+SIZE folds rotate, encode and un-rotate into one
  // pass; the owner itself is visited last so a lone requester is re-picked.
  always_comb begin
    o_any   = |i_req;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 1; k <= SIZE; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= SIZE) w_pos = w_pos - SIZE;
      if (!w_found && i_req[IW'(w_pos)]) begin
        w_found = 1'b1;
        o_idx   = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/lane_rr_arbiter.sv
// Packet-holding round-robin arbiter for SIZE lanes onto one channel.
// Optional stall timeout enabled by defining LANE_ARB_TIMEOUT_EN.
module lane_rr_arbiter
  import lane_arb_pkg::*;
#(
  parameter int unsigned SIZE     = LANE_SIZE,
  parameter int unsigned W        = LANE_W,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SIZE-1:0]         i_req,
  input  logic [SIZE-1:0]         i_last,
  input  logic [SIZE-1:0][W-1:0]  i_data,
  input  logic                    i_ready,
  output logic [SIZE-1:0]         o_gnt,
  output logic                    o_valid,
  output logic [W-1:0]            o_data,
  output logic                    o_last,
  output logic [$clog2(SIZE)-1:0] o_owner,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int unsigned IW = $clog2(SIZE);

  arb_state_e      r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [SIZE-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_xfer;
  logic            w_release;
  logic            w_expire;
  logic            w_take;

  rr_pick #(.SIZE(SIZE)) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  always_comb begin
    o_busy    = (r_state == GRANT);
    o_valid   = o_busy & i_req[r_owner];
    o_last    = o_valid & i_last[r_owner];
    o_data    = o_busy ? i_data[r_owner] : '0;
    o_gnt     = r_gnt;
    o_owner   = r_owner;
    w_xfer    = o_valid & i_ready;
    w_release = (w_xfer & i_last[r_owner]) | w_expire;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_take      = 1'b0;
    case (r_state)
      IDLE:  w_take = w_pick_any;
      GRANT: begin
        if (w_release) begin
          w_take = w_pick_any;
          if (!w_pick_any) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
    endcase
    if (w_take) begin
      w_state_nxt            = GRANT;
      w_owner_nxt            = w_pick_idx;
      w_ptr_nxt              = w_pick_idx;
      w_gnt_nxt              = '0;
      w_gnt_nxt[w_pick_idx]  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= IW'(SIZE - 1);
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

`ifdef LANE_ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold;
  logic          r_timeout;

  assign w_expire  = o_busy & ~w_xfer & (r_hold == HW'(MAX_HOLD - 1));
  assign o_timeout = r_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (!o_busy || w_xfer || w_release) r_hold <= '0;
      else                                r_hold <= r_hold + HW'(1);
    end
  end
`else
  assign w_expire  = 1'b0 & (MAX_HOLD != 0);
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Self-checking bench for lane_rr_arbiter: vector table, directed corner cases, random vs model.
module tb_lane_rr_arbiter;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int MH = 4;

  logic                   clk = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic [N-1:0]           i_req = '0;
  logic [N-1:0]           i_last = '0;
  logic [N-1:0][DW-1:0]   i_data = '0;
  logic                   i_ready = 1'b0;
  logic [N-1:0]           o_gnt;
  logic                   o_valid;
  logic [DW-1:0]          o_data;
  logic                   o_last;
  logic [$clog2(N)-1:0]   o_owner;
  logic                   o_busy;
  logic                   o_timeout;

  logic [N-1:0][DW-1:0]   tb_data = '0;

  always #5 clk = ~clk;

  lane_rr_arbiter #(.SIZE(N), .W(DW), .MAX_HOLD(MH)) dut (
    .i_clk    (clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_last   (i_last),
    .i_data   (i_data),
    .i_ready  (i_ready),
    .o_gnt    (o_gnt),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_owner  (o_owner),
    .o_busy   (o_busy),
    .o_timeout(o_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the channel, where the search starts, stall count.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int l;
      l = (ptr + k) % N;
      if (req[l]) return l;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_ptr   = N - 1;
    m_hold  = 0;
    m_to    = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0]  g;
    logic          v;
    logic [DW-1:0] d;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    v = m_busy && i_req[m_owner];
    d = m_busy ? i_data[m_owner] : '0;
    chk("gnt",     32'(o_gnt),     32'(g));
    chk("valid",   32'(o_valid),   32'(v));
    chk("data",    32'(o_data),    32'(d));
    chk("last",    32'(o_last),    32'(v && i_last[m_owner]));
    chk("owner",   32'(o_owner),   32'(m_owner));
    chk("busy",    32'(o_busy),    32'(m_busy));
    chk("timeout", 32'(o_timeout), 32'(m_to));
  endtask

  task automatic model_step();
    int w;
    bit xfer, expire, rel;
    w    = pick(i_req, m_ptr);
    m_to = 0;
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_ptr = w;
      end
      m_hold = 0;
    end else begin
      xfer   = i_req[m_owner] && i_ready;
      expire = 0;
`ifdef LANE_ARB_TIMEOUT_EN
      expire = !xfer && (m_hold == MH - 1);
`endif
      rel  = (xfer && i_last[m_owner]) || expire;
      m_to = expire;
      if (rel) begin
        m_hold = 0;
        if (w >= 0) begin
          m_owner = w; m_ptr = w;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_hold = xfer ? 0 : m_hold + 1;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] last, input logic rdy);
    @(negedge clk);
    i_rst_n = 1'b1;
    i_req   = req;
    i_last  = last;
    i_ready = rdy;
    i_data  = tb_data;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic do_reset(input logic [N-1:0] req);
    @(negedge clk);
    i_req   = req;
    i_rst_n = 1'b0;
    #1;
    chk("rst_gnt",     32'(o_gnt),     32'd0);
    chk("rst_busy",    32'(o_busy),    32'd0);
    chk("rst_valid",   32'(o_valid),   32'd0);
    chk("rst_data",    32'(o_data),    32'd0);
    chk("rst_owner",   32'(o_owner),   32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         ready;
    logic [N-1:0] exp_gnt;
    logic         exp_valid;
  } vec_t;

  vec_t tbl[10];

  initial begin
    for (int l = 0; l < N; l++) tb_data[l] = DW'(8'hA0 + l);

    // Fairness: every lane sends single-beat packets; grants walk 0..7 then wrap.
    tbl[0] = '{req: 8'hFF, last: 8'hFF, ready: 1'b1, exp_gnt: 8'h00, exp_valid: 1'b0};
    for (int i = 1; i < 10; i++)
      tbl[i] = '{req: 8'hFF, last: 8'hFF, ready: 1'b1,
                 exp_gnt: N'(1) << ((i - 1) % N), exp_valid: 1'b1};

    do_reset(8'hFF);
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].req, tbl[i].last, tbl[i].ready);
      chk("tbl_gnt",   32'(o_gnt),   32'(tbl[i].exp_gnt));
      chk("tbl_valid", 32'(o_valid), 32'(tbl[i].exp_valid));
    end

    // Packet hold: lane 3 four beats, beat 2 stalled 3 cycles, lane 5 waiting.
    do_reset('0);
    tb_data[5] = 8'h55;
    cycle(8'h28, 8'h00, 1'b1);
    chk("hold_idle", 32'(o_gnt), 32'h00);
    for (int b = 1; b <= 4; b++) begin
      tb_data[3] = DW'(8'h30 + b);
      if (b == 2) begin
        for (int s = 0; s < 3; s++) begin
          cycle(8'h28, 8'h00, 1'b0);
          chk("stall_gnt",  32'(o_gnt),  32'h08);
          chk("stall_data", 32'(o_data), 32'h32);
        end
      end
      cycle(8'h28, (b == 4) ? 8'h08 : 8'h00, 1'b1);
      chk("beat_gnt",  32'(o_gnt),  32'h08);
      chk("beat_data", 32'(o_data), 32'(8'h30 + b));
    end
    cycle(8'h20, 8'h20, 1'b1);
    chk("hold_next", 32'(o_gnt), 32'h20);

    // Wrap/gap: pointer parked at 6, only lanes 1 and 7 request.
    do_reset('0);
    cycle(8'h40, 8'hFF, 1'b1);
    cycle(8'hC2, 8'hFF, 1'b1);
    chk("wrap_6", 32'(o_gnt), 32'h40);
    cycle(8'h82, 8'hFF, 1'b1);
    chk("wrap_7", 32'(o_gnt), 32'h80);
    cycle(8'h02, 8'hFF, 1'b1);
    chk("wrap_1", 32'(o_gnt), 32'h02);

    // Owner gap: lane 2 drops its request for 5 cycles mid-packet.
    do_reset('0);
    cycle(8'h14, 8'h00, 1'b1);
    cycle(8'h14, 8'h00, 1'b1);
    chk("gap_start", 32'(o_gnt), 32'h04);
    for (int j = 0; j < 5; j++) begin
      cycle(8'h10, 8'h00, 1'b1);
`ifdef LANE_ARB_TIMEOUT_EN
      chk("gap_gnt", 32'(o_gnt),     (j < 4) ? 32'h04 : 32'h10);
      chk("gap_to",  32'(o_timeout), (j == 4) ? 32'd1 : 32'd0);
`else
      chk("gap_gnt",   32'(o_gnt),   32'h04);
      chk("gap_valid", 32'(o_valid), 32'd0);
`endif
    end
    cycle(8'h14, 8'h04, 1'b1);
    cycle(8'h10, 8'h10, 1'b1);
    chk("gap_end", 32'(o_gnt), 32'h10);

    // Mid-packet reset during lane 2's second beat, lane 0 then wins.
    do_reset('0);
    cycle(8'h04, 8'h00, 1'b1);
    cycle(8'h04, 8'h00, 1'b1);
    chk("mid_beat1", 32'(o_gnt), 32'h04);
    do_reset(8'h05);
    cycle(8'h05, 8'h00, 1'b1);
    chk("mid_idle", 32'(o_gnt), 32'h00);
    cycle(8'h05, 8'h00, 1'b1);
    chk("mid_lane0", 32'(o_gnt), 32'h01);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] rq, ls;
      for (int l = 0; l < N; l++) begin
        tb_data[l] = DW'($urandom);
        rq[l] = ($urandom_range(0, 9) < 4);
        ls[l] = $urandom_range(0, 1) != 0;
      end
      if ($urandom_range(0, 399) == 0) do_reset(rq);
      cycle(rq, ls, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
